// File: rtl/envelope_gen_if.sv
// Control-unit <-> envelope generator bundle.
//   envelopes[N_SEG] : per-segment rate (signed 16, two's complement) and duration (ticks)
//   cmds             : command byte; one bit requests a restart
//   amp              : 32-bit unsigned saturating amplitude
//   seg              : current segment index
//   active / done    : high while running / after the last segment finished
//   state            : raw FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
// master = control-unit side, slave = envelope_gen.
// Valid/ready: there is no handshake. envelopes and cmds are level signals
// sampled on every sample_clk edge; outputs are valid every cycle after reset.
`ifndef ENVELOPE_LEN
`define ENVELOPE_LEN 4
`endif
`ifndef ENVELOPE_RESET_BIT
`define ENVELOPE_RESET_BIT 0
`endif

interface envelope_gen_if #(
  parameter int N_SEG = `ENVELOPE_LEN
);
  localparam int SEG_W = (N_SEG > 1) ? $clog2(N_SEG) : 1;

  typedef struct packed {
    logic [15:0] rate;
    logic [7:0]  duration;
  } envelope_t;

  envelope_t        envelopes [N_SEG];
  logic [7:0]       cmds;
  logic [31:0]      amp;
  logic [SEG_W-1:0] seg;
  logic             active;
  logic             done;
  logic [1:0]       state;

  modport master (output envelopes, cmds, input amp, seg, active, done, state);
  modport slave  (input envelopes, cmds, output amp, seg, active, done, state);
endinterface

// File: rtl/envelope_gen.sv
// Per-oscillator envelope generator. Walks N_SEG segments in order, adding
// the live segment rate (sign-extended, shifted by RATE_SHIFT) to a 32-bit
// saturating amplitude every sample. Each segment lasts duration*TICK_DIV
// cycles; a latched duration of 0 sustains the segment until restart.
// A rising edge on cmds[RESET_BIT] restarts from segment 0 in any state.
// Ports: sample_clk (clock), rstn (async active-low reset), bus (slave
// modport of envelope_gen_if carrying envelopes/cmds in, amp/seg/active/
// done/state out). All outputs come straight from flops.
module envelope_gen #(
  parameter int N_SEG      = `ENVELOPE_LEN,
  parameter int TICK_DIV   = 48,
  parameter int RATE_SHIFT = 8,
  parameter int RESET_BIT  = `ENVELOPE_RESET_BIT
) (
  input  logic           sample_clk,
  input  logic           rstn,
  envelope_gen_if.slave  bus
);
  localparam int SEG_W  = (N_SEG > 1) ? $clog2(N_SEG) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [SEG_W-1:0]  LAST_SEG = SEG_W'(N_SEG - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       amp_q, amp_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [7:0]        dur_q, dur_d;
  logic              prev_rst_q, prev_rst_d;
  logic              active_q, active_d;
  logic              done_q, done_d;

  logic              rst_bit;
  logic              restart;
  logic [15:0]       cur_rate;
  logic signed [33:0] rate_step;
  logic signed [33:0] sum;
  logic [31:0]       amp_sat;
  logic [SEG_W-1:0]  seg_nxt;
  logic              unused_cmds;

  assign unused_cmds = ^bus.cmds;

  always_comb begin
    rst_bit    = bus.cmds[RESET_BIT];
    restart    = rst_bit & ~prev_rst_q;
    prev_rst_d = rst_bit;

    // 34-bit signed sum: bit 33 flags a negative result, bit 32 an overflow
    // past 2^32-1; the rate is read live from the current segment.
    cur_rate  = bus.envelopes[seg_q].rate;
    rate_step = $signed({{18{cur_rate[15]}}, cur_rate}) <<< RATE_SHIFT;
    sum       = $signed({2'b00, amp_q}) + rate_step;
    if (sum[33])      amp_sat = 32'd0;
    else if (sum[32]) amp_sat = 32'hFFFF_FFFF;
    else              amp_sat = sum[31:0];

    seg_nxt = seg_q + SEG_W'(1);

    state_d  = state_q;
    amp_d    = amp_q;
    seg_d    = seg_q;
    tick_d   = tick_q;
    dur_d    = dur_q;
    active_d = active_q;
    done_d   = done_q;

    if (restart) begin
      // Restart beats any segment advance in the same cycle.
      state_d  = ST_RUN;
      amp_d    = 32'd0;
      seg_d    = '0;
      dur_d    = bus.envelopes[0].duration;
      tick_d   = TICK_MAX;
      active_d = 1'b1;
      done_d   = 1'b0;
    end else if (state_q == ST_RUN) begin
      amp_d = amp_sat;
      // dur_q == 0 only when a zero duration was latched: sustain.
      if (dur_q != 8'd0) begin
        if (tick_q != '0) begin
          tick_d = tick_q - TICK_W'(1);
        end else begin
          tick_d = TICK_MAX;
          if (dur_q != 8'd1) begin
            dur_d = dur_q - 8'd1;
          end else if (seg_q != LAST_SEG) begin
            seg_d = seg_nxt;
            dur_d = bus.envelopes[seg_nxt].duration;
          end else begin
            state_d  = ST_DONE;
            dur_d    = 8'd0;
            active_d = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge sample_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      amp_q      <= 32'd0;
      seg_q      <= '0;
      tick_q     <= '0;
      dur_q      <= 8'd0;
      prev_rst_q <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      amp_q      <= amp_d;
      seg_q      <= seg_d;
      tick_q     <= tick_d;
      dur_q      <= dur_d;
      prev_rst_q <= prev_rst_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign bus.amp    = amp_q;
  assign bus.seg    = seg_q;
  assign bus.active = active_q;
  assign bus.done   = done_q;
  assign bus.state  = state_q;
endmodule

// File: tb/tb_envelope_gen.sv
module tb_envelope_gen;
  localparam int N_SEG      = 4;
  localparam int TICK_DIV   = 4;
  localparam int RATE_SHIFT = 8;
  localparam int RESET_BIT  = 0;
  localparam int W          = 36;

  // clock / reset
  logic sample_clk = 1'b0;
  logic rstn;
  always #5 sample_clk = ~sample_clk;

  envelope_gen_if #(.N_SEG(N_SEG)) bus ();

  envelope_gen #(
    .N_SEG(N_SEG), .TICK_DIV(TICK_DIV), .RATE_SHIFT(RATE_SHIFT), .RESET_BIT(RESET_BIT)
  ) dut (
    .sample_clk(sample_clk),
    .rstn(rstn),
    .bus(bus)
  );

  typedef struct {
    logic        rst_bit;
    logic [31:0] amp;
    logic [1:0]  seg;
    logic        active;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [W-1:0] dut_out();
    return {bus.amp, bus.seg, bus.active, bus.done};
  endfunction

  task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got amp=%0d seg=%0d active=%b done=%b, want amp=%0d seg=%0d active=%b done=%b",
               name, act[35:4], act[3:2], act[1], act[0], exp[35:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // driver tasks
  task automatic set_seg(input int i, input logic [15:0] rate, input logic [7:0] dur);
    bus.envelopes[i].rate     = rate;
    bus.envelopes[i].duration = dur;
  endtask

  task automatic drive_rst(input logic b);
    bus.cmds[RESET_BIT] = b;
  endtask

  task automatic step();
    @(posedge sample_clk);
    #1;
    if (exp_q.size() > 0) compare(name_q.pop_front(), dut_out(), exp_q.pop_front());
  endtask

  task automatic step_check(input string name, input logic [31:0] a, input logic [1:0] s,
                            input logic ac, input logic d);
    exp_q.push_back({a, s, ac, d});
    name_q.push_back(name);
    step();
  endtask

  task automatic apply_table(input string name);
    foreach (vecs[i]) begin
      drive_rst(vecs[i].rst_bit);
      step_check($sformatf("%s[%0d]", name, i), vecs[i].amp, vecs[i].seg,
                 vecs[i].active, vecs[i].done);
    end
    vecs.delete();
  endtask

  initial begin
    longint a;
    vec_t v;

    rstn     = 1'b0;
    bus.cmds = 8'd0;
    for (int i = 0; i < N_SEG; i++) set_seg(i, 16'd0, 8'd0);
    #12;
    compare("reset_state", dut_out(), {32'd0, 2'd0, 1'b0, 1'b0});
    total++;
    if (bus.state !== 2'd0) begin
      bad++;
      $display("FAIL reset_fsm: got state=%0d want 0", bus.state);
    end
    @(posedge sample_clk); #1;
    rstn = 1'b1;
    step_check("idle_hold", 32'd0, 2'd0, 1'b0, 1'b0);

    // Basic walk: rate +1000 for 2 ticks, then sustain at rate 0.
    set_seg(0, 16'd1000, 8'd2);
    set_seg(1, 16'd0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      v.rst_bit = (i < 2);
      v.amp     = 32'd256000 * ((i > 8) ? 8 : i);
      v.seg     = (i >= 8) ? 2'd1 : 2'd0;
      v.active  = 1'b1;
      v.done    = 1'b0;
      vecs.push_back(v);
    end
    apply_table("walk");

    // Asynchronous reset while RUN with nonzero amp, checked between edges.
    #2;
    rstn = 1'b0;
    #1;
    compare("async_reset", dut_out(), {32'd0, 2'd0, 1'b0, 1'b0});
    @(posedge sample_clk); #1;
    rstn = 1'b1;
    step_check("post_reset_idle", 32'd0, 2'd0, 1'b0, 1'b0);

    // Saturation high, then clamp at zero with the most negative rate.
    set_seg(0, 16'h7FFF, 8'd255);
    set_seg(1, 16'h8000, 8'd0);
    for (int e = 1; e <= 1540; e++) begin
      drive_rst(e <= 2);
      if (e <= 1021) begin
        a = 64'd8388352 * longint'(e - 1);
        if (a > 64'hFFFF_FFFF) a = 64'hFFFF_FFFF;
      end else begin
        a = 64'd4294967295 - 64'd8388608 * longint'(e - 1021);
        if (a < 0) a = 0;
      end
      step_check($sformatf("sat[%0d]", e), a[31:0], (e >= 1021) ? 2'd1 : 2'd0, 1'b1, 1'b0);
    end

    // Sustain for 1000 cycles, then a restart edge.
    set_seg(0, 16'd100, 8'd1);
    set_seg(1, 16'd0, 8'd0);
    drive_rst(1'b1);
    step_check("sus_restart", 32'd0, 2'd0, 1'b1, 1'b0);
    for (int e = 2; e <= 5; e++) begin
      drive_rst(e <= 2);
      step_check($sformatf("sus_ramp[%0d]", e), 32'd25600 * (e - 1),
                 (e == 5) ? 2'd1 : 2'd0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 1000; i++) step_check("sus_hold", 32'd102400, 2'd1, 1'b1, 1'b0);
    drive_rst(1'b1);
    step_check("sus_exit", 32'd0, 2'd0, 1'b1, 1'b0);
    step_check("sus_exit_held", 32'd25600, 2'd0, 1'b1, 1'b0);
    drive_rst(1'b0);
    step_check("sus_exit_run", 32'd51200, 2'd0, 1'b1, 1'b0);

    // Completion: four 1-tick segments at rate +1.
    for (int i = 0; i < N_SEG; i++) set_seg(i, 16'd1, 8'd1);
    for (int i = 0; i < 20; i++) begin
      v.rst_bit = (i < 2);
      v.amp     = 32'd256 * ((i > 16) ? 16 : i);
      v.seg     = (i >= 12) ? 2'd3 : 2'(i / 4);
      v.active  = (i < 16);
      v.done    = (i >= 16);
      vecs.push_back(v);
    end
    apply_table("done");
    drive_rst(1'b1);
    step_check("done_clear", 32'd0, 2'd0, 1'b1, 1'b0);

    // Restart landing on a segment-end cycle; new seg0 duration must reload.
    set_seg(0, 16'd1, 8'd1);
    set_seg(1, 16'd1, 8'd1);
    drive_rst(1'b0);
    step();
    for (int e = 1; e <= 4; e++) begin
      drive_rst(e <= 2);
      step_check($sformatf("coll_pre[%0d]", e), 32'd256 * (e - 1), 2'd0, 1'b1, 1'b0);
    end
    set_seg(0, 16'd1, 8'd2);
    drive_rst(1'b1);
    step_check("coll_restart", 32'd0, 2'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      drive_rst(k == 1);
      step_check($sformatf("coll_post[%0d]", k), 32'd256 * k,
                 (k >= 8) ? 2'd1 : 2'd0, 1'b1, 1'b0);
    end

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
